lcd_char_refresh_ctrl: RTL and testbench

//  Parametrised HD44780-class character-LCD controller. It runs the power-up init sequence, then

---
 rtl/lcd_pkg.sv | 42 ++++
 rtl/lcd_bus_timer.sv | 47 ++++
 rtl/lcd_char_refresh_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_lcd_char_refresh_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state enum and helpers for the character-LCD refresh controller.
//   - HD44780 command bytes used by the init sequence and the refresh loop
//   - lcd_state_e: controller FSM states
//   - row_base(): DDRAM start address of each display row
//   - clog2_min1(): counter/address width that never collapses to zero bits
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC  = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] CMD_DOFF  = 8'h08;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_DON   = 8'h0C;
    localparam logic [7:0] CMD_CGRAM = 8'h40;
    localparam logic [7:0] CMD_DDRAM = 8'h80;

    typedef enum logic [3:0] {
        ST_PWRUP,
        ST_FUNC,
        ST_DOFF,
        ST_CLR,
        ST_ENTRY,
        ST_DON,
        ST_CG_ADDR,
        ST_CG_DATA,
        ST_ROW_ADDR,
        ST_ROW_DATA
    } lcd_state_e;

    function automatic logic [6:0] row_base(input logic [1:0] r);
        case (r)
            2'd0:    return 7'h00;
            2'd1:    return 7'h40;
            2'd2:    return 7'h14;
            default: return 7'h54;
        endcase
    endfunction

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// lcd_bus_timer: power-up delay followed by a free-running bus transfer timer.
//   i_clk, i_rst_n : clock, async active-low reset
//   o_start        : high in the last power-up cycle (the first byte is loaded on that edge)
//   o_en           : LCD E strobe, high for the first half of every transfer period
//   o_tick         : high in the last cycle of every transfer period
// CLK_PWRUP must be at least 1.
module lcd_bus_timer
    import lcd_pkg::*;
#(
    parameter int CLK_PWRUP    = 1000000,
    parameter int CLK_PER_XFER = 100000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_start,
    output logic o_en,
    output logic o_tick
);

    localparam int PW = clog2_min1(CLK_PWRUP + 1);
    localparam int XW = clog2_min1(CLK_PER_XFER);

    logic [PW-1:0] r_pwr_cnt;
    logic [XW-1:0] r_xc;
    logic          w_pwr_done;

    assign w_pwr_done = (r_pwr_cnt == '0);

    // xc is held at 0 until the power-up down-counter reaches terminal count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pwr_cnt <= PW'(CLK_PWRUP);
            r_xc      <= '0;
        end else if (!w_pwr_done) begin
            r_pwr_cnt <= r_pwr_cnt - PW'(1);
        end else if (r_xc == XW'(CLK_PER_XFER - 1)) begin
            r_xc <= '0;
        end else begin
            r_xc <= r_xc + XW'(1);
        end
    end

    assign o_start = (r_pwr_cnt == PW'(1));
    assign o_en    = w_pwr_done && (r_xc < XW'(CLK_PER_XFER / 2));
    assign o_tick  = w_pwr_done && (r_xc == XW'(CLK_PER_XFER - 1));

endmodule

// File: rtl/lcd_char_refresh_ctrl.sv
// lcd_char_refresh_ctrl: HD44780-class LCD controller. Runs the init sequence, then loops
// forever uploading the glyph buffer (when dirty) and refreshing DDRAM from the frame buffer.
//   clk, rst_n                 : clock, async active-low reset
//   fb_we/fb_addr/fb_data      : frame-buffer write port, cell = row*COLS+col
//   cg_we/cg_addr/cg_data      : glyph-buffer write port, addr = glyph*8+row
//   lcd_en/rw/rs/data/on       : LCD pins
//   init_done                  : sticky once the init sequence has completed
//   frame_tick                 : 1-clk pulse on the tick that finishes the last cell of a pass
//
// The state names the byte currently on the bus; each tick retires it and loads the next.
//   state     | meaning
//   PWRUP     | power-up wait, bus idle
//   FUNC      | function set 0x38 on bus
//   DOFF      | display off 0x08 on bus
//   CLR       | clear 0x01 on bus
//   ENTRY     | entry mode 0x06 on bus
//   DON       | display on 0x0C on bus; init_done set when it retires
//   CG_ADDR   | CGRAM address 0x40 on bus
//   CG_DATA   | glyph byte r_gidx on bus
//   ROW_ADDR  | DDRAM address of row r_row on bus
//   ROW_DATA  | frame-buffer cell (r_row, r_col) on bus
module lcd_char_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int ROWS         = 2,
    parameter int COLS         = 16,
    parameter int NGLYPH       = 8,
    parameter int CLK_PWRUP    = 1000000,
    parameter int CLK_PER_XFER = 100000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                fb_we,
    input  logic [clog2_min1(ROWS*COLS)-1:0]    fb_addr,
    input  logic [7:0]                          fb_data,
    input  logic                                cg_we,
    input  logic [5:0]                          cg_addr,
    input  logic [4:0]                          cg_data,
    output logic                                lcd_en,
    output logic                                lcd_rw,
    output logic                                lcd_rs,
    output logic [7:0]                          lcd_data,
    output logic                                lcd_on,
    output logic                                init_done,
    output logic                                frame_tick
);

    localparam int NCELL  = ROWS * COLS;
    localparam int AW     = clog2_min1(NCELL);
    localparam int NGB    = NGLYPH * 8;
    localparam int GDEPTH = (NGB > 0) ? NGB : 1;
    localparam int GW     = clog2_min1(GDEPTH);
    localparam int RW     = clog2_min1(ROWS);
    localparam int CW     = clog2_min1(COLS);

    lcd_state_e     r_state, w_state_nxt;
    logic [7:0]     r_data, w_byte;
    logic           r_rs, w_rs;
    logic           r_init_done, r_cg_dirty;
    logic [RW-1:0]  r_row;
    logic [CW-1:0]  r_col, w_col_rd;
    logic [GW-1:0]  r_gidx, w_g_rd;
    logic [AW-1:0]  w_fb_raddr;
    logic [7:0]     r_fb [NCELL];
    logic [4:0]     r_cg [GDEPTH];
    logic           w_start, w_en, w_tick;
    logic           w_col_last, w_row_last, w_g_last;
    logic           w_pass_start, w_row_start;
    logic           w_fb_wr, w_cg_wr;

    lcd_bus_timer #(
        .CLK_PWRUP    (CLK_PWRUP),
        .CLK_PER_XFER (CLK_PER_XFER)
    ) u_timer (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .o_start (w_start),
        .o_en    (w_en),
        .o_tick  (w_tick)
    );

    // Address range checks only exist when the port can express an out-of-range value.
    generate
        if (NCELL == (1 << AW)) begin : g_fb_full
            assign w_fb_wr = fb_we;
        end else begin : g_fb_part
            assign w_fb_wr = fb_we && (fb_addr < AW'(NCELL));
        end
        if (NGB == 0) begin : g_cg_none
            logic w_unused_cg;
            assign w_unused_cg = ^{cg_addr, cg_data};
            assign w_cg_wr     = 1'b0;
        end else if (NGB == 64) begin : g_cg_full
            assign w_cg_wr = cg_we;
        end else begin : g_cg_part
            assign w_cg_wr = cg_we && (cg_addr < 6'(NGB));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCELL; i++) r_fb[i] <= 8'h20;
        end else if (w_fb_wr) begin
            r_fb[fb_addr] <= fb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GDEPTH; i++) r_cg[i] <= '0;
        end else if (w_cg_wr) begin
            r_cg[cg_addr[GW-1:0]] <= cg_data;
        end
    end

    assign w_col_last = (r_col == CW'(COLS - 1));
    assign w_row_last = (r_row == RW'(ROWS - 1));
    assign w_g_last   = (r_gidx == GW'(NGB - 1));

    // Read address of the byte that the coming tick will load.
    assign w_col_rd   = (r_state == ST_ROW_DATA && !w_col_last) ? r_col + CW'(1) : '0;
    assign w_g_rd     = (r_state == ST_CG_DATA && !w_g_last) ? r_gidx + GW'(1) : '0;
    assign w_fb_raddr = AW'(int'(r_row) * COLS + int'(w_col_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_PWRUP;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_byte       = r_data;
        w_rs         = r_rs;
        w_pass_start = 1'b0;
        w_row_start  = 1'b0;
        case (r_state)
            ST_PWRUP:    if (w_start) begin w_state_nxt = ST_FUNC;  w_byte = CMD_FUNC;  w_rs = 1'b0; end
            ST_FUNC:     if (w_tick)  begin w_state_nxt = ST_DOFF;  w_byte = CMD_DOFF;  end
            ST_DOFF:     if (w_tick)  begin w_state_nxt = ST_CLR;   w_byte = CMD_CLR;   end
            ST_CLR:      if (w_tick)  begin w_state_nxt = ST_ENTRY; w_byte = CMD_ENTRY; end
            ST_ENTRY:    if (w_tick)  begin w_state_nxt = ST_DON;   w_byte = CMD_DON;   end
            ST_DON:      if (w_tick)  w_pass_start = 1'b1;
            ST_CG_ADDR:  if (w_tick) begin
                             w_state_nxt = ST_CG_DATA;
                             w_byte      = {3'b000, r_cg[w_g_rd]};
                             w_rs        = 1'b1;
                         end
            ST_CG_DATA:  if (w_tick) begin
                             if (w_g_last) w_row_start = 1'b1;
                             else          w_byte = {3'b000, r_cg[w_g_rd]};
                         end
            ST_ROW_ADDR: if (w_tick) begin
                             w_state_nxt = ST_ROW_DATA;
                             w_byte      = r_fb[w_fb_raddr];
                             w_rs        = 1'b1;
                         end
            ST_ROW_DATA: if (w_tick) begin
                             if (!w_col_last) begin
                                 w_byte = r_fb[w_fb_raddr];
                             end else if (!w_row_last) begin
                                 w_state_nxt = ST_ROW_ADDR;
                                 w_byte      = CMD_DDRAM | {1'b0, row_base(2'(r_row) + 2'd1)};
                                 w_rs        = 1'b0;
                             end else begin
                                 w_pass_start = 1'b1;
                             end
                         end
            default: ;
        endcase
        if (w_pass_start) begin
            if (r_cg_dirty && (NGB > 0)) begin
                w_state_nxt = ST_CG_ADDR;
                w_byte      = CMD_CGRAM;
                w_rs        = 1'b0;
            end else begin
                w_row_start = 1'b1;
            end
        end
        if (w_row_start) begin
            w_state_nxt = ST_ROW_ADDR;
            w_byte      = CMD_DDRAM | {1'b0, row_base(2'd0)};
            w_rs        = 1'b0;
        end
    end

    always_comb begin
        lcd_en     = w_en;
        lcd_rw     = 1'b0;
        lcd_on     = 1'b1;
        lcd_data   = r_data;
        lcd_rs     = r_rs;
        init_done  = r_init_done;
        frame_tick = w_tick && (r_state == ST_ROW_DATA) && w_col_last && w_row_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_rs        <= 1'b0;
            r_init_done <= 1'b0;
            r_cg_dirty  <= 1'b1;
            r_row       <= '0;
            r_col       <= '0;
            r_gidx      <= '0;
        end else begin
            r_data <= w_byte;
            r_rs   <= w_rs;
            // A host glyph write always wins over the clear on entry to CG_ADDR.
            if (cg_we)
                r_cg_dirty <= 1'b1;
            else if (w_tick && w_state_nxt == ST_CG_ADDR)
                r_cg_dirty <= 1'b0;
            if (w_tick) begin
                case (r_state)
                    ST_DON:      r_init_done <= 1'b1;
                    ST_CG_ADDR:  r_gidx <= '0;
                    ST_CG_DATA:  r_gidx <= w_g_rd;
                    ST_ROW_ADDR: r_col <= '0;
                    ST_ROW_DATA: begin
                        r_col <= w_col_rd;
                        if (w_col_last) r_row <= w_row_last ? '0 : r_row + RW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_char_refresh_ctrl.sv
module tb_lcd_char_refresh_ctrl;

    localparam int ROWS  = 2;
    localparam int COLS  = 4;
    localparam int NGLY  = 1;
    localparam int PWR   = 20;
    localparam int PX    = 4;
    localparam int NCELL = ROWS * COLS;
    localparam int AW    = 3;
    localparam int NGB   = NGLY * 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fb_we = 1'b0;
    logic [AW-1:0] fb_addr = '0;
    logic [7:0]    fb_data = '0;
    logic          cg_we = 1'b0;
    logic [5:0]    cg_addr = '0;
    logic [4:0]    cg_data = '0;
    logic          lcd_en, lcd_rw, lcd_rs, lcd_on, init_done, frame_tick;
    logic [7:0]    lcd_data;

    always #5 clk = ~clk;

    lcd_char_refresh_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .NGLYPH(NGLY), .CLK_PWRUP(PWR), .CLK_PER_XFER(PX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .cg_we(cg_we), .cg_addr(cg_addr), .cg_data(cg_data),
        .lcd_en(lcd_en), .lcd_rw(lcd_rw), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
        .lcd_on(lcd_on), .init_done(init_done), .frame_tick(frame_tick)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model: byte stream as an ordered list of slots ----------------
    typedef struct { logic [7:0] data; logic rs; logic idone; logic last; } exp_t;
    typedef struct { int kind; int idx; bit last; } slot_t;   // kind 0 const, 1 glyph, 2 cell

    exp_t       sb[$];
    slot_t      m_slots[$];
    logic [7:0] m_fb [NCELL];
    logic [4:0] m_cg [NGB];
    bit         m_dirty;
    int         m_edge;
    int         m_nload;
    int         base_tab [4];

    task automatic push_slot(input int kind, input int idx, input bit last);
        slot_t s;
        s.kind = kind; s.idx = idx; s.last = last;
        m_slots.push_back(s);
    endtask

    task automatic m_reset();
        for (int i = 0; i < NCELL; i++) m_fb[i] = 8'h20;
        for (int i = 0; i < NGB; i++) m_cg[i] = 5'h00;
        m_dirty = 1'b1;
        m_edge  = 0;
        m_nload = 0;
        base_tab = '{'h00, 'h40, 'h14, 'h54};
        m_slots.delete();
        sb.delete();
        push_slot(0, 'h38, 0); push_slot(0, 'h08, 0); push_slot(0, 'h01, 0);
        push_slot(0, 'h06, 0); push_slot(0, 'h0C, 0);
    endtask

    task automatic m_build_pass();
        if (m_dirty) begin
            m_dirty = 1'b0;
            push_slot(0, 'h40, 0);
            for (int k = 0; k < NGB; k++) push_slot(1, k, 0);
        end
        for (int r = 0; r < ROWS; r++) begin
            push_slot(0, 'h80 + base_tab[r], 0);
            for (int c = 0; c < COLS; c++)
                push_slot(2, r * COLS + c, (r == ROWS - 1) && (c == COLS - 1));
        end
    endtask

    task automatic m_load();
        slot_t s;
        exp_t  e;
        if (m_slots.size() == 0) m_build_pass();
        s = m_slots.pop_front();
        case (s.kind)
            0:       e.data = 8'(s.idx);
            1:       e.data = {3'b000, m_cg[s.idx]};
            default: e.data = m_fb[s.idx];
        endcase
        e.rs    = (s.kind != 0);
        e.idone = (m_nload >= 5);
        e.last  = s.last;
        sb.push_back(e);
        m_nload++;
    endtask

    // Bytes are latched on the power-up expiry edge and then once per transfer period;
    // the cell/glyph value is taken before any host write on that same edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_reset();
            end else begin
                m_edge++;
                if (m_edge >= PWR && ((m_edge - PWR) % PX) == 0) m_load();
                if (fb_we && int'(fb_addr) < NCELL) m_fb[fb_addr] = fb_data;
                if (cg_we) begin
                    m_dirty = 1'b1;
                    if (int'(cg_addr) < NGB) m_cg[cg_addr[2:0]] = cg_data;
                end
            end
        end
    end

    // ---------------- monitor: compares on every E falling edge ----------------
    logic       mon_prev_en = 1'b0;
    logic [7:0] mon_prev_d = '0;
    logic       mon_prev_rs = 1'b0;
    bit         mon_last = 1'b0;
    int         pops = 0;
    int         exp_ft = 0;
    int         ft_seen = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_prev_en = 1'b0;
                mon_last    = 1'b0;
            end else begin
                if (mon_prev_en && lcd_en)
                    chk("stable_while_e", 32'({lcd_rs, lcd_data}), 32'({mon_prev_rs, mon_prev_d}));
                if (mon_prev_en && !lcd_en) begin
                    if (sb.size() == 0) begin
                        chk("scoreboard_empty", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        chk("lcd_data", 32'(lcd_data), 32'(e.data));
                        chk("lcd_rs", 32'(lcd_rs), 32'(e.rs));
                        chk("init_done", 32'(init_done), 32'(e.idone));
                        chk("rw_on", 32'({lcd_rw, lcd_on}), 32'd1);
                        pops++;
                        mon_last = e.last;
                        if (e.last) exp_ft++;
                    end
                end
                if (frame_tick) begin
                    chk("frame_tick_after_last_cell", 32'(mon_last), 32'd1);
                    ft_seen++;
                    mon_last = 1'b0;
                end
                mon_prev_en = lcd_en;
                mon_prev_d  = lcd_data;
                mon_prev_rs = lcd_rs;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, 32'(lcd_data), 32'd0);
        chk({tag, "_rs"}, 32'(lcd_rs), 32'd0);
        chk({tag, "_en"}, 32'(lcd_en), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_rw_on"}, 32'({lcd_rw, lcd_on}), 32'd1);
    endtask

    // Called right after rst_n is released on a negedge; E must stay low for PWR cycles.
    task automatic check_pwrup();
        int k;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (lcd_en) break;
        end
        chk("pwrup_e_low_cycles", 32'(k), 32'(PWR));
    endtask

    task automatic wait_ft(input int n);
        int got = 0;
        for (int i = 0; i < 3000 && got < n; i++) begin
            @(negedge clk);
            if (frame_tick) got++;
        end
        if (got < n) chk("wait_frame_tick_timeout", 32'(got), 32'(n));
    endtask

    task automatic wait_byte(input logic [7:0] d, input logic rs);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (lcd_data == d && lcd_rs == rs) break;
        end
        if (i == 3000) chk("wait_byte_timeout", 32'(lcd_data), 32'(d));
    endtask

    task automatic fb_wr(input int a, input logic [7:0] d);
        @(negedge clk);
        fb_we = 1'b1; fb_addr = AW'(a); fb_data = d;
        @(negedge clk);
        fb_we = 1'b0;
    endtask

    task automatic cg_wr(input int a, input logic [4:0] d);
        @(negedge clk);
        cg_we = 1'b1; cg_addr = 6'(a); cg_data = d;
        @(negedge clk);
        cg_we = 1'b0;
    endtask

    task automatic rand_traffic(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            fb_we   = ($urandom_range(0, 3) == 0);
            fb_addr = AW'($urandom_range(0, NCELL - 1));
            fb_data = 8'($urandom_range(32, 126));
            cg_we   = ($urandom_range(0, 15) == 0);
            cg_addr = 6'($urandom_range(0, 15));
            cg_data = 5'($urandom);
        end
        @(negedge clk);
        fb_we = 1'b0;
        cg_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        check_pwrup();

        // init, one pass with glyph upload, one pass without
        wait_ft(2);

        // single cell write, then more passes
        fb_wr(5, 8'h41);
        wait_ft(2);

        // random host traffic overlapping refresh, including out-of-range glyph addresses
        rand_traffic(300);
        wait_ft(2);

        // glyph write landing in the middle of an upload
        cg_wr(0, 5'h11);
        wait_byte(8'h40, 1'b0);
        repeat (2 * PX) @(negedge clk);
        cg_wr(3, 5'h1F);
        wait_ft(3);

        // out-of-range glyph write still forces a re-upload
        cg_wr(40, 5'h07);
        wait_ft(2);

        // glyph write on the same tick that enters CG_ADDR: the clear must lose
        cg_wr(2, 5'h05);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (frame_tick) break;
        end
        cg_we = 1'b1; cg_addr = 6'd1; cg_data = 5'h0A;
        @(negedge clk);
        cg_we = 1'b0;
        wait_ft(3);

        rand_traffic(200);
        wait_ft(2);

        // asynchronous reset in the middle of row data
        wait_byte(8'hC0, 1'b0);
        repeat (PX + 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_pwrup();
        fb_wr(2, 8'h5A);
        wait_ft(2);

        repeat (10) @(negedge clk);
        chk("frame_tick_count", 32'(ft_seen), 32'(exp_ft));
        chk("bytes_compared_min", 32'(pops >= 150), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
